// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Parametrised register file with a per-register scoreboard.
//                NUM_RD asynchronous read ports, one synchronous write port,
//                optional write-to-read bypass, and a busy-bit scoreboard
//                that decode sets (reserve) and writeback clears (write).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1              clock, all state updates on posedge
//    rstn        in   1              asynchronous active-low reset
//    rd_addr_i   in   NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//    rd_data_o   out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
//    rd_busy_o   out  NUM_RD         port i's register has a pending write
//    wr_en_i     in   1              writeback write enable
//    wr_addr_i   in   ADDR_W         write address
//    wr_data_i   in   DATA_W         write data
//    rsv_en_i    in   1              reserve rsv_addr_i (mark busy)
//    rsv_addr_i  in   ADDR_W         register to reserve
//    flush_i     in   1              clear every busy bit, data untouched
//    busy_cnt_o  out  ADDR_W+1       registered population count of busy bits
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rsv_en_i,
    input  logic [ADDR_W-1:0]          rsv_addr_i,
    input  logic                       flush_i,
    output logic [ADDR_W:0]            busy_cnt_o
);

    localparam int c_depth  = 1 << ADDR_W;
    localparam bit c_zero   = (ZERO_REG != 0);
    localparam bit c_bypass = (BYPASS != 0);

    logic [DATA_W-1:0]  mem_q [c_depth];
    logic [c_depth-1:0] busy_q;
    logic [c_depth-1:0] busy_d;
    logic [ADDR_W:0]    busy_cnt_q;
    logic [ADDR_W:0]    busy_cnt_d;

    logic               w_wr_ok;
    logic               w_rsv_ok;

    // Register 0 is hard-wired when ZERO_REG is set: it never takes a write
    // and never becomes busy.
    assign w_wr_ok  = wr_en_i  && !(c_zero && (wr_addr_i  == '0));
    assign w_rsv_ok = rsv_en_i && !(c_zero && (rsv_addr_i == '0));

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = rd_addr_i[i*ADDR_W +: ADDR_W];
        // w_wr_ok already excludes register 0 when it is hard-wired.
        assign w_hit  = c_bypass && w_wr_ok && (wr_addr_i == w_addr);

        always_comb begin
            w_data = mem_q[w_addr];
            w_busy = busy_q[w_addr];
            if (!rstn || (c_zero && (w_addr == '0))) begin
                // Held in reset the outputs read zero even if a write is
                // presented, so the bypass path is masked as well.
                w_data = '0;
                w_busy = 1'b0;
            end else if (w_hit) begin
                // The producer is delivering now, so the value is no longer
                // pending from the consumer's point of view.
                w_data = wr_data_i;
                w_busy = 1'b0;
            end
        end

        assign rd_data_o[i*DATA_W +: DATA_W] = w_data;
        assign rd_busy_o[i]                  = w_busy;
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state: write-clear, then reserve, then flush, so the
    // later assignment wins (flush > reserve > write-clear).
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (w_wr_ok) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (w_rsv_ok) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    // The count is taken from the current busy bits and registered, so it
    // trails the scoreboard by one cycle and stays off the read timing path.
    always_comb begin
        busy_cnt_d = '0;
        for (int k = 0; k < c_depth; k++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_q[k]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage. Flush does not touch data, so a write on a flush edge lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < c_depth; k++) begin
                mem_q[k] <= '0;
            end
        end else if (w_wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_sb
//  Description : Self-checking bench for reg_file_sb. Two instances share
//                one stimulus: dut 0 (ZERO_REG=1, BYPASS=1) and dut 1
//                (ZERO_REG=0, BYPASS=0). A behavioural array model predicts
//                both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR*AW-1:0] rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             flush;

    wire  [NR*DW-1:0] rdd [2];
    wire  [NR-1:0]    rbz [2];
    wire  [AW:0]      cnt [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .rd_addr_i(rd_addr), .rd_data_o(rdd[0]), .rd_busy_o(rbz[0]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_cnt_o(cnt[0]));

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clk(clk), .rstn(rstn), .rd_addr_i(rd_addr), .rd_data_o(rdd[1]), .rd_busy_o(rbz[1]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_cnt_o(cnt[1]));

    // ------------------------------------------------------------------------
    // Reference model: plain arrays updated from the behavioural rules.
    // ------------------------------------------------------------------------
    logic [DW-1:0] mmem  [2][DEPTH];
    bit            mbusy [2][DEPTH];
    int            mcnt  [2];

    function automatic bit zr(input int d);
        return d == 0;
    endfunction

    function automatic bit bp(input int d);
        return d == 0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < DEPTH; k++) begin
                mmem[d][k]  = '0;
                mbusy[d][k] = 1'b0;
            end
            mcnt[d] = 0;
        end
    endtask

    // Apply the current inputs to the model, then advance one clock.
    task automatic tick();
        if (!rstn) begin
            model_clear();
        end else begin
            for (int d = 0; d < 2; d++) begin
                int n;
                n = 0;
                for (int k = 0; k < DEPTH; k++) n += int'(mbusy[d][k]);
                if (wr_en && !(zr(d) && wr_addr == 0)) begin
                    mmem[d][wr_addr]  = wr_data;
                    mbusy[d][wr_addr] = 1'b0;
                end
                if (rsv_en && !(zr(d) && rsv_addr == 0)) mbusy[d][rsv_addr] = 1'b1;
                if (flush) for (int k = 0; k < DEPTH; k++) mbusy[d][k] = 1'b0;
                mcnt[d] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_rd(input int d, input logic [AW-1:0] a,
                                   output logic [DW-1:0] ed, output logic eb);
        if (!rstn || (zr(d) && a == 0)) begin
            ed = '0; eb = 1'b0;
        end else if (bp(d) && wr_en && wr_addr == a) begin
            ed = wr_data; eb = 1'b0;
        end else begin
            ed = mmem[d][a]; eb = mbusy[d][a];
        end
    endfunction

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0003;
        set_rd(5'd3, 5'd3);
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NR; p++) begin
                total++;
                if (rdd[d][p*DW +: DW] !== 32'h0) begin
                    bad++; $display("FAIL reset_data dut%0d port%0d got=%h want=0", d, p, rdd[d][p*DW +: DW]);
                end
                total++;
                if (rbz[d][p] !== 1'b0) begin
                    bad++; $display("FAIL reset_busy dut%0d port%0d got=%b want=0", d, p, rbz[d][p]);
                end
            end
            total++;
            if (cnt[d] !== 6'd0) begin
                bad++; $display("FAIL reset_cnt dut%0d got=%0d want=0", d, cnt[d]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdd[d][DW-1:0] !== 32'h0) begin
                bad++; $display("FAIL reset_hold dut%0d got=%h want=0", d, rdd[d][DW-1:0]);
            end
        end
        rstn = 1'b1; idle();
        tick();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = 32'hA5000000 | k;
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle();
        tick();
        set_rd(5'd31, 5'd6);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdd[d][DW-1:0] !== 32'hA500001F) begin
                bad++; $display("FAIL pre_reset_data dut%0d got=%h want=a500001f", d, rdd[d][DW-1:0]);
            end
            total++;
            if (cnt[d] !== 6'd1) begin
                bad++; $display("FAIL pre_reset_cnt dut%0d got=%0d want=1", d, cnt[d]);
            end
        end
        // Assert reset mid-cycle: outputs must clear with no clock edge.
        rstn = 1'b0;
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(AW'(a), AW'(DEPTH - 1 - a));
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NR; p++) begin
                    total++;
                    if (rdd[d][p*DW +: DW] !== 32'h0 || rbz[d][p] !== 1'b0) begin
                        bad++; $display("FAIL async_reset dut%0d port%0d addr%0d got=%h/%b want=0/0",
                                        d, p, a, rdd[d][p*DW +: DW], rbz[d][p]);
                    end
                end
                total++;
                if (cnt[d] !== 6'd0) begin
                    bad++; $display("FAIL async_reset_cnt dut%0d got=%0d want=0", d, cnt[d]);
                end
            end
        end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44444444;
        tick();
        rstn = 1'b1; idle();
        set_rd(5'd4, 5'd31);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdd[d] !== 64'h0) begin
                bad++; $display("FAIL post_reset_data dut%0d got=%h want=0", d, rdd[d]);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BAD0005;
        tick();
        wr_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd5);
        #1;
        for (int p = 0; p < NR; p++) begin
            total++;
            if (rdd[0][p*DW +: DW] !== 32'hDEADBEEF) begin
                bad++; $display("FAIL bypass_on port%0d got=%h want=deadbeef", p, rdd[0][p*DW +: DW]);
            end
            total++;
            if (rdd[1][p*DW +: DW] !== 32'h0BAD0005) begin
                bad++; $display("FAIL bypass_off port%0d got=%h want=0bad0005", p, rdd[1][p*DW +: DW]);
            end
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdd[d][DW-1:0] !== 32'hDEADBEEF) begin
                bad++; $display("FAIL bypass_after dut%0d got=%h want=deadbeef", d, rdd[d][DW-1:0]);
            end
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        tick();
        set_rd(5'd0, 5'd0);
        #1;
        total++;
        if (rdd[0][DW-1:0] !== 32'h0 || rbz[0][0] !== 1'b0 || cnt[0] !== 6'd0) begin
            bad++; $display("FAIL zero_reg_on got=%h/%b/%0d want=0/0/0", rdd[0][DW-1:0], rbz[0][0], cnt[0]);
        end
        total++;
        if (rdd[1][DW-1:0] !== 32'hFFFFFFFF || rbz[1][0] !== 1'b1 || cnt[1] !== 6'd1) begin
            bad++; $display("FAIL zero_reg_off got=%h/%b/%0d want=ffffffff/1/1", rdd[1][DW-1:0], rbz[1][0], cnt[1]);
        end
        flush = 1'b1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_reserve_write();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        set_rd(5'd7, 5'd7);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rbz[d] !== 2'b11 || cnt[d] !== 6'd0) begin
                bad++; $display("FAIL reserve dut%0d got=%b/%0d want=11/0", d, rbz[d], cnt[d]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (cnt[d] !== 6'd1) begin
                bad++; $display("FAIL reserve_cnt dut%0d got=%0d want=1", d, cnt[d]);
            end
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77777777;
        #1;
        total++;
        if (rbz[0] !== 2'b00 || rdd[0][DW-1:0] !== 32'h77777777) begin
            bad++; $display("FAIL write_bypass_busy got=%b/%h want=00/77777777", rbz[0], rdd[0][DW-1:0]);
        end
        total++;
        if (rbz[1] !== 2'b11 || rdd[1][DW-1:0] !== 32'h0) begin
            bad++; $display("FAIL write_nobypass_busy got=%b/%h want=11/0", rbz[1], rdd[1][DW-1:0]);
        end
        tick();
        idle();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rbz[d] !== 2'b00 || cnt[d] !== 6'd1) begin
                bad++; $display("FAIL write_clear dut%0d got=%b/%0d want=00/1", d, rbz[d], cnt[d]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (cnt[d] !== 6'd0) begin
                bad++; $display("FAIL write_clear_cnt dut%0d got=%0d want=0", d, cnt[d]);
            end
        end
    endtask

    task automatic test_same_edge();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        idle();
        set_rd(5'd9, 5'd4);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdd[d][DW-1:0] !== 32'h12345678 || rbz[d] !== 2'b11) begin
                bad++; $display("FAIL rsv_wr_same dut%0d got=%h/%b want=12345678/11", d, rdd[d][DW-1:0], rbz[d]);
            end
        end
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0F0F0F0F;
        tick();
        idle();
        set_rd(5'd3, 5'd4);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rbz[d] !== 2'b00 || rdd[d][2*DW-1:DW] !== 32'h0F0F0F0F) begin
                bad++; $display("FAIL flush_rsv dut%0d got=%b/%h want=00/0f0f0f0f", d, rbz[d], rdd[d][2*DW-1:DW]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (cnt[d] !== 6'd0) begin
                bad++; $display("FAIL flush_cnt dut%0d got=%0d want=0", d, cnt[d]);
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k < DEPTH; k++) begin
            rsv_en = 1'b1; rsv_addr = AW'(k);
            tick();
        end
        rsv_addr = 5'd1;
        tick();
        idle();
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (cnt[d] !== 6'd31) begin
                bad++; $display("FAIL fill_cnt dut%0d got=%0d want=31", d, cnt[d]);
            end
        end
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        tick();
        set_rd(5'd0, 5'd31);
        #1;
        total++;
        if (cnt[0] !== 6'd31 || rbz[0] !== 2'b10) begin
            bad++; $display("FAIL fill_max_zr got=%0d/%b want=31/10", cnt[0], rbz[0]);
        end
        total++;
        if (cnt[1] !== 6'd32 || rbz[1] !== 2'b11) begin
            bad++; $display("FAIL fill_max_nz got=%0d/%b want=32/11", cnt[1], rbz[1]);
        end
        flush = 1'b1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            logic [AW-1:0] a0;
            logic [AW-1:0] a1;
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 9) < 4);
            rsv_addr = AW'($urandom_range(0, DEPTH - 1));
            flush    = ($urandom_range(0, 49) == 0);
            a0 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 3))
                0:       a1 = a0;
                1:       a1 = 5'd0;
                default: a1 = AW'($urandom_range(0, DEPTH - 1));
            endcase
            set_rd(a0, a1);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NR; p++) begin
                    logic [DW-1:0] ed;
                    logic          eb;
                    exp_rd(d, (p == 0) ? a0 : a1, ed, eb);
                    total++;
                    if (rdd[d][p*DW +: DW] !== ed || rbz[d][p] !== eb) begin
                        bad++; $display("FAIL rand_read cyc%0d dut%0d port%0d got=%h/%b want=%h/%b",
                                        c, d, p, rdd[d][p*DW +: DW], rbz[d][p], ed, eb);
                    end
                end
                total++;
                if (cnt[d] !== 6'(mcnt[d])) begin
                    bad++; $display("FAIL rand_cnt cyc%0d dut%0d got=%0d want=%0d", c, d, cnt[d], mcnt[d]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rstn = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        model_clear();
        test_reset();
        test_async_reset();
        test_bypass();
        test_zero_reg();
        test_reserve_write();
        test_same_edge();
        test_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
